// File: rtl/feature_frame_packer_if.sv
// Stream-in / frame-out bundle for feature_frame_packer.
// The slave modport is the packer; the master modport is the producer/consumer side.
interface feature_frame_packer_if #(
  parameter int unsigned NUM_CHANNEL   = 4,
  parameter int unsigned CHANNEL_WIDTH = 2,
  parameter int unsigned CNT_WIDTH     = 16
);
  logic                                   ch_valid;
  logic                                   ch_ready;
  logic [CHANNEL_WIDTH-1:0]               ch_data;
  logic                                   ch_last;
  logic                                   fout_valid;
  logic                                   fout_ready;
  logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0]   features_top;
  logic                                   frame_err;
  logic [CNT_WIDTH-1:0]                   frame_cnt;

  modport master (
    output ch_valid, ch_data, ch_last, fout_ready,
    input  ch_ready, fout_valid, features_top, frame_err, frame_cnt
  );

  modport slave (
    input  ch_valid, ch_data, ch_last, fout_ready,
    output ch_ready, fout_valid, features_top, frame_err, frame_cnt
  );
endinterface

// File: rtl/feature_frame_packer.sv
// Packs a serial per-channel feature stream into flat frames using two ping-pong slots.
// Short or long frames are dropped and flagged with a one-cycle frame_err pulse.
module feature_frame_packer #(
  parameter int unsigned NUM_CHANNEL   = 4,
  parameter int unsigned CHANNEL_WIDTH = 2,
  parameter int unsigned IDX_WIDTH     = $clog2(NUM_CHANNEL),
  parameter int unsigned CNT_WIDTH     = 16
) (
  input logic                   clk,
  input logic                   rst,
  feature_frame_packer_if.slave bus
);
  localparam int unsigned FW = NUM_CHANNEL * CHANNEL_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CHANNEL - 1);

  typedef enum logic {FILL, DISCARD} state_t;

  state_t                r_state, w_state_nxt;
  logic [FW-1:0]         r_slot [2];
  logic [1:0]            r_full, w_full_nxt;
  logic                  r_wr_sel, w_wr_sel_nxt;
  logic                  r_rd_sel, w_rd_sel_nxt;
  logic [IDX_WIDTH-1:0]  r_idx, w_idx_nxt;
  logic                  r_frame_err, w_frame_err_nxt;
  logic [CNT_WIDTH-1:0]  r_frame_cnt, w_frame_cnt_nxt;
  logic [FW-1:0]         r_features_top, w_head_nxt;
  logic [FW-1:0]         w_slot_new;
  logic                  w_ch_ready, w_beat, w_drain, w_write_en;

  assign w_ch_ready = (r_state == DISCARD) | ~r_full[r_wr_sel];
  assign w_beat     = bus.ch_valid & w_ch_ready;
  assign w_write_en = w_beat & (r_state == FILL);
  assign w_drain    = r_full[r_rd_sel] & bus.fout_ready;

  // Arrival index k lands at field NUM_CHANNEL-1-k, so channel 0 ends up in the MSBs.
  always_comb begin
    w_slot_new = r_slot[r_wr_sel];
    for (int unsigned c = 0; c < NUM_CHANNEL; c++) begin
      if (IDX_WIDTH'(c) == r_idx)
        w_slot_new[(NUM_CHANNEL-1-c)*CHANNEL_WIDTH +: CHANNEL_WIDTH] = bus.ch_data;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_full_nxt      = r_full;
    w_wr_sel_nxt    = r_wr_sel;
    w_rd_sel_nxt    = r_rd_sel;
    w_idx_nxt       = r_idx;
    w_frame_err_nxt = 1'b0;
    w_frame_cnt_nxt = r_frame_cnt;

    if (w_drain) begin
      w_full_nxt[r_rd_sel] = 1'b0;
      w_rd_sel_nxt         = ~r_rd_sel;
    end

    // Completion needs ~full[wr_sel] and drain needs full[rd_sel], so they never touch the same slot.
    case (r_state)
      FILL: begin
        if (w_beat) begin
          if (r_idx != LAST_IDX) begin
            if (bus.ch_last) begin
              w_idx_nxt       = '0;
              w_frame_err_nxt = 1'b1;
            end else begin
              w_idx_nxt = r_idx + IDX_WIDTH'(1);
            end
          end else begin
            w_idx_nxt = '0;
            if (bus.ch_last) begin
              w_full_nxt[r_wr_sel] = 1'b1;
              w_wr_sel_nxt         = ~r_wr_sel;
              w_frame_cnt_nxt      = r_frame_cnt + CNT_WIDTH'(1);
            end else begin
              w_state_nxt = DISCARD;
            end
          end
        end
      end
      DISCARD: begin
        if (w_beat && bus.ch_last) begin
          w_state_nxt     = FILL;
          w_frame_err_nxt = 1'b1;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // Output register follows the head slot only while it is full, so it holds the last frame when empty.
  always_comb begin
    w_head_nxt = r_features_top;
    if (w_full_nxt[w_rd_sel_nxt])
      w_head_nxt = (w_write_en && (r_wr_sel == w_rd_sel_nxt)) ? w_slot_new : r_slot[w_rd_sel_nxt];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= FILL;
      r_slot[0]      <= '0;
      r_slot[1]      <= '0;
      r_full         <= '0;
      r_wr_sel       <= 1'b0;
      r_rd_sel       <= 1'b0;
      r_idx          <= '0;
      r_frame_err    <= 1'b0;
      r_frame_cnt    <= '0;
      r_features_top <= '0;
    end else begin
      r_state        <= w_state_nxt;
      if (w_write_en)
        r_slot[r_wr_sel] <= w_slot_new;
      r_full         <= w_full_nxt;
      r_wr_sel       <= w_wr_sel_nxt;
      r_rd_sel       <= w_rd_sel_nxt;
      r_idx          <= w_idx_nxt;
      r_frame_err    <= w_frame_err_nxt;
      r_frame_cnt    <= w_frame_cnt_nxt;
      r_features_top <= w_head_nxt;
    end
  end

  assign bus.ch_ready     = w_ch_ready;
  assign bus.fout_valid   = r_full[r_rd_sel];
  assign bus.features_top = r_features_top;
  assign bus.frame_err    = r_frame_err;
  assign bus.frame_cnt    = r_frame_cnt;
endmodule

// File: tb/tb_feature_frame_packer.sv
// Directed and randomized checks of feature_frame_packer against a frame-level reference:
// expected frames are queued as packed values and matched on every output handshake.
module tb_feature_frame_packer;
  localparam int unsigned NC   = 4;
  localparam int unsigned CW   = 2;
  localparam int unsigned CNTW = 16;

  typedef int unsigned beats_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  feature_frame_packer_if #(.NUM_CHANNEL(NC), .CHANNEL_WIDTH(CW), .CNT_WIDTH(CNTW)) bus ();

  feature_frame_packer #(
    .NUM_CHANNEL(NC), .CHANNEL_WIDTH(CW), .IDX_WIDTH(2), .CNT_WIDTH(CNTW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned err_seen = 0;
  int unsigned good_cnt = 0;
  logic [7:0]  exp_q[$];
  bit          mon_en = 1'b0;
  bit          rand_done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame value: channel 0 is the most significant base-4 digit.
  function automatic logic [7:0] pack(input beats_t v);
    int unsigned p = 0;
    foreach (v[k]) p = p * 4 + v[k];
    return 8'(p);
  endfunction

  // n beats taken from the base-4 digits of val, most significant first.
  function automatic beats_t mkq(input int unsigned val, input int unsigned n);
    beats_t q;
    for (int unsigned k = 0; k < n; k++) q.push_back((val >> (2 * (n - 1 - k))) & 3);
    return q;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (bus.frame_err) err_seen++;
      if (mon_en && bus.fout_valid && bus.fout_ready) begin
        if (exp_q.size() == 0) chk("unexpected_frame", {56'h0, bus.features_top}, 64'h1_0000);
        else chk("frame_data", {56'h0, bus.features_top}, {56'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_beat(input logic [1:0] d, input logic last);
    int unsigned waited = 0;
    bit acc = 1'b0;
    bus.ch_valid = 1'b1;
    bus.ch_data  = d;
    bus.ch_last  = last;
    while (!acc) begin
      @(negedge clk);
      acc = bus.ch_ready;
      @(posedge clk); #1;
      waited++;
      if (!acc && waited > 300) begin
        chk("beat_timeout", waited, 0);
        break;
      end
    end
    bus.ch_valid = 1'b0;
    bus.ch_last  = 1'b0;
  endtask

  task automatic send_frame(input beats_t v, input int unsigned gap_max);
    foreach (v[k]) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      send_beat(2'(v[k]), k == v.size() - 1);
    end
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); #1; n++; end
    chk("drain_pending", exp_q.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e0, inj, len, r;
    beats_t f;
    bus.ch_valid = 1'b0; bus.ch_data = '0; bus.ch_last = 1'b0; bus.fout_ready = 1'b0;

    #12;
    chk("rst_valid", bus.fout_valid, 0);
    chk("rst_data",  bus.features_top, 0);
    chk("rst_ready", bus.ch_ready, 1);
    chk("rst_cnt",   bus.frame_cnt, 0);
    chk("rst_err",   bus.frame_err, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Basic pack, one cycle latency
    bus.fout_ready = 1'b1;
    f = mkq('hE4, 4); exp_q.push_back(pack(f)); good_cnt++;
    send_frame(f, 0);
    chk("t1_valid", bus.fout_valid, 1);
    chk("t1_data",  bus.features_top, 8'hE4);
    chk("t1_cnt",   bus.frame_cnt, 1);
    wait_idle();

    // Both slots full, third frame stalls until a drain
    bus.fout_ready = 1'b0;
    f = mkq('h1B, 4); exp_q.push_back(pack(f)); send_frame(f, 0);
    f = mkq('hF0, 4); exp_q.push_back(pack(f)); send_frame(f, 0);
    good_cnt += 3;
    chk("t2_ready_low", bus.ch_ready, 0);
    chk("t2_valid",     bus.fout_valid, 1);
    chk("t2_head",      bus.features_top, 8'h1B);
    f = mkq('h9C, 4); exp_q.push_back(pack(f));
    fork
      send_frame(f, 0);
      begin
        repeat (4) begin @(posedge clk); #1; end
        chk("t2_hold",  bus.features_top, 8'h1B);
        chk("t2_stall", bus.ch_ready, 0);
        bus.fout_ready = 1'b1;
      end
    join
    wait_idle();
    chk("t2_cnt", bus.frame_cnt, 4);

    // Short frame dropped, next frame packs
    e0 = err_seen;
    send_frame(mkq('hB, 2), 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("t3_err",     err_seen - e0, 1);
    chk("t3_novalid", bus.fout_valid, 0);
    chk("t3_cnt",     bus.frame_cnt, 4);
    f = mkq('h55, 4); exp_q.push_back(pack(f)); good_cnt++;
    send_frame(f, 0);
    chk("t3_data", bus.features_top, 8'h55);
    wait_idle();

    // Long frame dropped, next frame packs
    e0 = err_seen;
    send_frame(mkq('hABC, 6), 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("t4_err",     err_seen - e0, 1);
    chk("t4_novalid", bus.fout_valid, 0);
    chk("t4_cnt",     bus.frame_cnt, 5);
    f = mkq('hCC, 4); exp_q.push_back(pack(f)); good_cnt++;
    send_frame(f, 0);
    chk("t4_data", bus.features_top, 8'hCC);
    chk("t4_cnt2", bus.frame_cnt, 6);
    wait_idle();

    // Reset mid-frame with a frame held
    bus.fout_ready = 1'b0;
    f = mkq('h6C, 4); exp_q.push_back(pack(f)); good_cnt++;
    send_frame(f, 0);
    chk("t5_held", bus.fout_valid, 1);
    send_beat(2'd2, 1'b0);
    send_beat(2'd2, 1'b0);
    rst = 1'b0;
    #1;
    chk("t5_valid", bus.fout_valid, 0);
    chk("t5_data",  bus.features_top, 0);
    chk("t5_ready", bus.ch_ready, 1);
    chk("t5_cnt",   bus.frame_cnt, 0);
    exp_q.delete();
    good_cnt = 0;
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.fout_ready = 1'b1;
    f = mkq('hA5, 4); exp_q.push_back(pack(f)); good_cnt++;
    send_frame(f, 0);
    chk("t5_data2", bus.features_top, 8'hA5);
    chk("t5_cnt2",  bus.frame_cnt, 1);
    wait_idle();

    // Random traffic with ~10% malformed frames
    e0 = err_seen;
    inj = 0;
    fork
      begin
        for (int unsigned fr = 0; fr < 1000; fr++) begin
          r = $urandom_range(0, 9);
          if (r == 0) begin
            len = ($urandom_range(0, 1) == 1) ? $urandom_range(1, NC - 1) : $urandom_range(NC + 1, NC + 3);
            inj++;
          end else begin
            len = NC;
          end
          f.delete();
          for (int unsigned k = 0; k < len; k++) f.push_back($urandom_range(0, 3));
          if (len == NC) begin
            exp_q.push_back(pack(f));
            good_cnt++;
          end
          send_frame(f, 2);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          bus.fout_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.fout_ready = 1'b1;
    wait_idle();
    repeat (3) begin @(posedge clk); #1; end
    chk("rand_err", err_seen - e0, inj);
    chk("rand_cnt", bus.frame_cnt, CNTW'(good_cnt));
    chk("rand_valid_idle", bus.fout_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
